// File: rtl/exp_trace_pkg.sv
// ============================================================================
// Module      : exp_trace_pkg
// Description : Shared types, default parameters and decay-floor helper for
//               the exponential trace bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exp_trace_pkg;

   localparam int unsigned c_N_CH_DEF        = 4;
   localparam int unsigned c_W_W_DEF         = 8;
   localparam int unsigned c_TR_W_DEF        = 16;
   localparam int unsigned c_W_SHIFT_DEF     = 8;
   localparam int unsigned c_DECAY_SHIFT_DEF = 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // A nonzero trace always loses at least one LSB so it reaches zero.
   function automatic logic [31:0] decay_amount(input logic [31:0] trace,
                                                input int unsigned shift);
      logic [31:0] d;
      d = trace >> shift;
      if (d == 32'd0 && trace != 32'd0) begin
         d = 32'd1;
      end
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/exp_trace_step.sv
// ============================================================================
// Module      : exp_trace_step
// Description : Combinational single-channel decay + weighted-increment update
//               with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_trace_step
   import exp_trace_pkg::*;
#(
   parameter int unsigned W_W         = c_W_W_DEF,
   parameter int unsigned TR_W        = c_TR_W_DEF,
   parameter int unsigned W_SHIFT     = c_W_SHIFT_DEF,
   parameter int unsigned DECAY_SHIFT = c_DECAY_SHIFT_DEF
)(
   input  logic [TR_W-1:0] i_trace,
   input  logic            i_pending,
   input  logic [W_W-1:0]  i_weight,
   output logic [TR_W-1:0] o_trace,
   output logic            o_sat
);

   logic [TR_W-1:0] w_decay;
   logic [TR_W:0]   w_inc;
   logic [TR_W:0]   w_sum;

   // One extra bit of headroom exposes the carry used for saturation.
   always_comb begin
      w_decay = TR_W'(decay_amount(32'(i_trace), DECAY_SHIFT));
      w_inc   = i_pending ? ((TR_W+1)'(i_weight) << W_SHIFT) : '0;
      w_sum   = {1'b0, i_trace - w_decay} + w_inc;
   end

   assign o_sat   = w_sum[TR_W];
   assign o_trace = o_sat ? '1 : w_sum[TR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/exp_trace_bank.sv
// ============================================================================
// Module      : exp_trace_bank
// Description : Multi-channel fixed-point decaying synaptic trace bank, one
//               channel updated per clock in a tick-started sweep.
//               Optional macro TRACE_SUM_EN adds a registered trace_sum output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_trace_bank
   import exp_trace_pkg::*;
#(
   parameter int unsigned N_CH        = c_N_CH_DEF,
   parameter int unsigned W_W         = c_W_W_DEF,
   parameter int unsigned TR_W        = c_TR_W_DEF,
   parameter int unsigned W_SHIFT     = c_W_SHIFT_DEF,
   parameter int unsigned DECAY_SHIFT = c_DECAY_SHIFT_DEF
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick,
   input  logic [N_CH-1:0]        spike_in,
   input  logic [N_CH*W_W-1:0]    weight_in,
   output logic [N_CH*TR_W-1:0]   trace_out,
   output logic [N_CH-1:0]        sat_out,
   output logic                   busy,
   output logic                   sweep_done,
   output logic                   tick_overrun
`ifdef TRACE_SUM_EN
   ,
   output logic [TR_W+$clog2(N_CH)-1:0] trace_sum
`endif
);

   localparam int unsigned IDX_W = $clog2(N_CH);
   localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_CH - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [TR_W-1:0]   r_trace [N_CH];
   logic [N_CH-1:0]   r_pending;
   logic [N_CH-1:0]   w_pending_nxt;
   logic [N_CH-1:0]   r_sat;
   logic              r_sweep_done;
   logic              r_overrun;
   logic              w_process;
   logic              w_last;
   logic [W_W-1:0]    w_weight;
   logic [TR_W-1:0]   w_new;
   logic              w_sat;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_process   = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (tick) begin
               w_state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            w_process = 1'b1;
            if (r_idx == c_LAST) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_weight = weight_in[r_idx*W_W +: W_W];

   exp_trace_step #(
      .W_W         (W_W),
      .TR_W        (TR_W),
      .W_SHIFT     (W_SHIFT),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_step (
      .i_trace   (r_trace[r_idx]),
      .i_pending (r_pending[r_idx]),
      .i_weight  (w_weight),
      .o_trace   (w_new),
      .o_sat     (w_sat)
   );

   // A spike landing in the channel's own processing cycle keeps it pending.
   always_comb begin
      w_pending_nxt = r_pending;
      for (int i = 0; i < N_CH; i++) begin
         w_pending_nxt[i] = spike_in[i] |
                            (r_pending[i] & ~(w_process && (r_idx == IDX_W'(i))));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            r_trace[i] <= '0;
         end
         r_pending    <= '0;
         r_sat        <= '0;
         r_idx        <= '0;
         r_sweep_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_pending    <= w_pending_nxt;
         r_sweep_done <= w_last;
         if (w_process) begin
            r_trace[r_idx] <= w_new;
            r_sat[r_idx]   <= w_sat;
            r_idx          <= r_idx + IDX_W'(1);
         end else if (tick) begin
            r_idx <= '0;
         end
         if (tick && r_state == SWEEP) begin
            r_overrun <= 1'b1;
         end
      end
   end

   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_trace_out
         assign trace_out[g*TR_W +: TR_W] = r_trace[g];
      end
   endgenerate

   assign sat_out      = r_sat;
   assign busy         = (r_state == SWEEP);
   assign sweep_done   = r_sweep_done;
   assign tick_overrun = r_overrun;

`ifdef TRACE_SUM_EN
   localparam int unsigned SUM_W = TR_W + $clog2(N_CH);

   logic [SUM_W-1:0] r_acc;
   logic [SUM_W-1:0] r_trace_sum;
   logic [SUM_W-1:0] w_acc_nxt;

   assign w_acc_nxt = ((r_idx == '0) ? '0 : r_acc) + SUM_W'(w_new);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= '0;
         r_trace_sum <= '0;
      end else begin
         if (w_process) begin
            r_acc <= w_acc_nxt;
         end
         if (w_last) begin
            r_trace_sum <= w_acc_nxt;
         end
      end
   end

   assign trace_sum = r_trace_sum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exp_trace_bank.sv
// ============================================================================
// Module      : tb_exp_trace_bank
// Description : Scoreboard bench for exp_trace_bank with directed sweeps and
//               hand-computed expected traces (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exp_trace_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic [3:0]  spike_in;
   logic [31:0] weight_in;
   logic [63:0] trace_out;
   logic [3:0]  sat_out;
   logic        busy;
   logic        sweep_done;
   logic        tick_overrun;
`ifdef TRACE_SUM_EN
   logic [17:0] trace_sum;
`endif

   exp_trace_bank dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .spike_in     (spike_in),
      .weight_in    (weight_in),
      .trace_out    (trace_out),
      .sat_out      (sat_out),
      .busy         (busy),
      .sweep_done   (sweep_done),
      .tick_overrun (tick_overrun)
`ifdef TRACE_SUM_EN
      ,
      .trace_sum    (trace_sum)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [63:0] tr;
      logic [3:0]  sat;
      logic        ovr;
      int          done_cyc;
      logic [17:0] sum;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Monitor: every sweep_done pops one expected record.
   always @(negedge clk) begin
      if (reset === 1'b0 && sweep_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_sweep_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            for (int i = 0; i < 4; i++) begin
               chk($sformatf("trace%0d", i), 64'(trace_out[i*16 +: 16]),
                   64'(mon_e.tr[i*16 +: 16]));
            end
            chk("sat_out", 64'(sat_out), 64'(mon_e.sat));
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("tick_overrun", 64'(tick_overrun), 64'(mon_e.ovr));
`ifdef TRACE_SUM_EN
            chk("trace_sum", 64'(trace_sum), 64'(mon_e.sum));
`endif
         end
      end
   end

   task automatic run_sweep(input logic [3:0] pre, input bit late2, input bit ovr_tick,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3,
                            input logic [3:0] esat, input bit eovr);
      exp_t e;
      if (pre != 4'd0) begin
         spike_in = pre;
         @(negedge clk);
         spike_in = 4'd0;
      end
      e.tr       = {e3, e2, e1, e0};
      e.sat      = esat;
      e.ovr      = eovr;
      e.done_cyc = cyc + 5;
      e.sum      = 18'(e0) + 18'(e1) + 18'(e2) + 18'(e3);
      sb_q.push_back(e);
      tick = 1'b1;
      @(negedge clk);                       // T+1
      tick = 1'b0;
      @(negedge clk);                       // T+2
      if (ovr_tick) tick = 1'b1;
      @(negedge clk);                       // T+3: channel 2 processing
      tick = 1'b0;
      if (late2) spike_in = 4'b0100;
      @(negedge clk);                       // T+4
      spike_in = 4'd0;
      @(negedge clk);                       // T+5: sweep_done
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      tick      = 1'b0;
      spike_in  = 4'd0;
      weight_in = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_trace", trace_out, 64'd0);
      chk("rst_sat", 64'(sat_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(sweep_done), 64'd0);
      chk("rst_overrun", 64'(tick_overrun), 64'd0);
      reset = 1'b0;

      // Reset in the middle of a sweep with pending spikes and an overrun.
      weight_in = {8'h00, 8'h20, 8'h00, 8'h10};
      @(negedge clk);
      spike_in = 4'b0101;
      @(negedge clk);
      spike_in = 4'd0;
      tick     = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("mid_trace0_latency", 64'(trace_out[15:0]), 64'h1000);
      chk("mid_busy", 64'(busy), 64'd1);
      tick = 1'b1;
      @(negedge clk);
      chk("mid_overrun", 64'(tick_overrun), 64'd1);
      tick  = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_trace", trace_out, 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_sat", 64'(sat_out), 64'd0);
      chk("midrst_overrun", 64'(tick_overrun), 64'd0);

      // Pending spikes must not survive reset.
      run_sweep(4'b0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0);

      weight_in = {8'hF0, 8'h00, 8'h03, 8'h10};
      run_sweep(4'b1011, 0, 0, 16'h1000, 16'h0300, 16'h0000, 16'hF000, 4'b0000, 0);
      weight_in = {8'hFF, 8'h00, 8'h03, 8'h10};
      run_sweep(4'b1000, 0, 0, 16'h0800, 16'h0180, 16'h0000, 16'hFFFF, 4'b1000, 0);
      run_sweep(4'b0000, 0, 0, 16'h0400, 16'h00C0, 16'h0000, 16'h8000, 4'b0000, 0);
      weight_in = {8'hFF, 8'h20, 8'h03, 8'h10};
      run_sweep(4'b0000, 1, 0, 16'h0200, 16'h0060, 16'h0000, 16'h4000, 4'b0000, 0);
      run_sweep(4'b0000, 0, 1, 16'h0100, 16'h0030, 16'h2000, 16'h2000, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0080, 16'h0018, 16'h1000, 16'h1000, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0040, 16'h000C, 16'h0800, 16'h0800, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0020, 16'h0006, 16'h0400, 16'h0400, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0010, 16'h0003, 16'h0200, 16'h0200, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0008, 16'h0002, 16'h0100, 16'h0100, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0004, 16'h0001, 16'h0080, 16'h0080, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0002, 16'h0000, 16'h0040, 16'h0040, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0001, 16'h0000, 16'h0020, 16'h0020, 4'b0000, 1);
      run_sweep(4'b0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 4'b0000, 1);

      // No decay without tick.
      repeat (20) @(negedge clk);
      chk("idle_hold", trace_out, 64'h0010_0010_0000_0000);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/exp_trace_bank.md
Name: exp_trace_bank

Overview:
- Multi-channel, synthesizable, fixed-point successor to the single-channel real-valued spike-triggered exponential kernel.
- Holds one decaying synaptic trace per input channel. A spike adds a weighted increment; every tick applies multiplicative decay (y -= y >> DECAY_SHIFT).
- Channels are updated time-multiplexed, one per clk, in a sweep started by tick.
- Sits between spike sources and the neuron membrane integrator.

Parameters:
- N_CH, 4, number of channels (>=2).
- W_W, 8, weight width per channel (unsigned).
- TR_W, 16, trace width (unsigned).
- W_SHIFT, 8, left shift applied to the weight before adding (W_W+W_SHIFT <= TR_W).
- DECAY_SHIFT, 1, decay factor 1 - 2^-DECAY_SHIFT per tick (1..TR_W-1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- tick  in  1  start a decay/update sweep over all channels.
- spike_in  in  N_CH  per-channel spike strobe, any cycle.
- weight_in  in  N_CH*W_W  per-channel weight, channel i at [i*W_W +: W_W].
- trace_out  out  N_CH*TR_W  registered traces, channel i at [i*TR_W +: TR_W].
- sat_out  out  N_CH  bit i = last update of channel i clamped.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse after the last channel update.
- tick_overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Reset values: all traces, pending, sat_out, busy, sweep_done, tick_overrun and idx = 0; FSM = IDLE.
- Reset mid-sweep aborts the sweep and clears all state.
- pending[i]:
  - Set on any cycle with spike_in[i]=1.
  - Cleared when channel i is processed.
  - A spike in the same cycle channel i is processed wins: pending stays 1 and the spike applies in the next sweep.
  - Multiple spikes between sweeps collapse to one increment.
- FSM states are IDLE and SWEEP.
  - IDLE to SWEEP: tick=1; idx <= 0; busy=1 from the next cycle.
  - Each SWEEP cycle processes channel idx, then idx++.
  - After processing idx==N_CH-1: go to IDLE, busy=0 and sweep_done=1 for exactly one cycle.
  - A tick while busy is ignored and sets tick_overrun.
- Update of channel idx (weight_in sampled in its processing cycle):
  - d = trace >> DECAY_SHIFT.
  - If d==0 and trace!=0, then d = 1. This floor guarantees decay to 0.
  - s = (trace - d) + (pending ? weight << W_SHIFT : 0), computed in TR_W+1 bits.
  - If s >= 2^TR_W: trace = all ones and sat_out[idx]=1; otherwise trace = s and sat_out[idx]=0.
- Latency: with tick sampled at cycle T, channel i's new value is visible on trace_out at cycle T+2+i.
- Untouched channels hold their value. No decay occurs without tick.

Optional Feature:
- Macro TRACE_SUM_EN.
- Defined:
  - Adds output trace_sum of width TR_W+$clog2(N_CH).
  - Accumulated over the post-update traces during the sweep.
  - Registered and valid in the sweep_done cycle; holds until the next sweep_done; 0 at reset.
- Undefined: the port and accumulator are absent; behaviour is otherwise identical.

Decomposition:
- Package exp_trace_pkg holds:
  - The state enum (IDLE, SWEEP).
  - Default parameter constants.
  - A function computing the decay floor.
- Sub-module exp_trace_step: combinational single-channel update (trace, pending, weight -> new trace, sat). It is instantiated once and muxed by idx.

Test Plan:
All scenarios use default parameters.
1. Reset: assert reset for 2 cycles mid-sweep -> trace_out=0, busy=0, sat_out=0, tick_overrun=0, FSM IDLE.
2. Spike ch0 with weight 0x10, then tick -> trace0=0x1000 after the sweep and sweep_done pulses once 5 cycles after tick. Next ticks give 0x0800, then 0x0400; other channels stay 0.
3. Decay floor: trace1=0x0003 -> 0x0002 -> 0x0001 -> 0x0000, then stays 0 on further ticks.
4. Saturation: trace3=0xF000 with a spike of weight 0xFF -> 0x7800+0xFF00 clamps to 0xFFFF and sat_out[3]=1. The next tick without a spike gives 0x8000 and sat_out[3]=0.
5. Spike on ch2 in its own processing cycle (T+3) -> trace2 gets no increment this sweep and the increment applies in the next sweep.
6. Tick during busy -> ignored, sweep length unchanged, tick_overrun=1 until reset. With TRACE_SUM_EN, trace_sum equals the sum of the four traces at sweep_done.
